// File: rtl/vmu_agen_seq_if.sv
// Command handshake between the VMU instruction sequencer and the address-generator sequencer.
interface vmu_agen_seq_if #(
  parameter int SCALAR_WIDTH = 32,
  parameter int VL_W         = 9
);
  logic                    i_cmd_vld;
  logic                    o_cmd_rdy;
  logic [SCALAR_WIDTH-1:0] i_cmd_scalar;
  logic [VL_W-1:0]         i_cmd_vl;

  modport master (output i_cmd_vld, output i_cmd_scalar, output i_cmd_vl, input o_cmd_rdy);
  modport slave  (input i_cmd_vld, input i_cmd_scalar, input i_cmd_vl, output o_cmd_rdy);
endinterface

// File: rtl/vmu_agen_seq.sv
// Steps the beat counter of one vector memory command into addr_gen and tags
// addr_gen's output with valid/last after its fixed latency.
module vmu_agen_seq #(
  parameter int SCALAR_WIDTH      = 32,
  parameter int COMMON_AGEN_DELAY = 2,
  parameter int SYS_VLMAX         = 256,
  parameter int SYS_NUM_LANE      = 8,
  parameter int CNT_W             = $clog2(SYS_VLMAX/SYS_NUM_LANE),
  parameter int VL_W              = $clog2(SYS_VLMAX)+1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vmu_agen_seq_if.slave           cmd,
  input  logic                    i_stall,
  output logic [CNT_W-1:0]        o_seq_vmu_cnt,
  output logic [SCALAR_WIDTH-1:0] o_seq_vmu_scalar,
  output logic                    o_addr_vld,
  output logic                    o_addr_last,
  output logic                    o_busy,
  output logic                    o_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  function automatic logic [VL_W-1:0] sat_vl(input logic [VL_W-1:0] vl);
    sat_vl = (vl > VL_W'(SYS_VLMAX)) ? VL_W'(SYS_VLMAX) : vl;
  endfunction

  function automatic logic [CNT_W:0] ceil_beats(input logic [VL_W-1:0] vl);
    logic [VL_W-1:0] sum;
    sum        = vl + VL_W'(SYS_NUM_LANE-1);
    ceil_beats = (CNT_W+1)'(sum / VL_W'(SYS_NUM_LANE));
  endfunction

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, beats_m1;
  logic [SCALAR_WIDTH-1:0] scalar_q;
  logic [CNT_W:0]          beats_in;
  logic                    zero_done, drain_done;
  logic                    rdy, accept, issue, last_beat, inflight;

  assign beats_in      = ceil_beats(sat_vl(cmd.i_cmd_vl));
  assign last_beat     = (cnt == beats_m1);
  assign accept        = rdy & cmd.i_cmd_vld;
  assign cmd.o_cmd_rdy = rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The zero-beat done cycle also blocks acceptance, so no command lands on a done pulse.
  always_comb begin
    state_nxt  = state;
    rdy        = 1'b0;
    o_busy     = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        rdy = ~zero_done;
        if (rdy && cmd.i_cmd_vld && (beats_in != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        o_busy = 1'b1;
        issue  = ~i_stall;
        if (issue && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (!inflight) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_done = drain_done | zero_done;

  // Command latch and beat counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      beats_m1  <= '0;
      scalar_q  <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= accept && (beats_in == '0);
      if (accept) begin
        scalar_q <= cmd.i_cmd_scalar;
        cnt      <= '0;
        beats_m1 <= CNT_W'(beats_in - 1'b1);
      end else if (issue && !last_beat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign o_seq_vmu_cnt    = cnt;
  assign o_seq_vmu_scalar = scalar_q;

  // Latency-matching delay line; advances every cycle so stalls never freeze in-flight beats
  if (COMMON_AGEN_DELAY == 0) begin : g_nodly
    assign o_addr_vld  = issue;
    assign o_addr_last = issue & last_beat;
    assign inflight    = 1'b0;
  end else begin : g_dly
    logic [COMMON_AGEN_DELAY-1:0] vld_dly, last_dly;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_dly  <= '0;
        last_dly <= '0;
      end else begin
        vld_dly  <= (vld_dly << 1)  | COMMON_AGEN_DELAY'(issue);
        last_dly <= (last_dly << 1) | COMMON_AGEN_DELAY'(issue & last_beat);
      end
    end
    assign o_addr_vld  = vld_dly[COMMON_AGEN_DELAY-1];
    assign o_addr_last = last_dly[COMMON_AGEN_DELAY-1];
    assign inflight    = |vld_dly;
  end

endmodule

// File: tb/tb_vmu_agen_seq.sv
// Directed and randomized bench for vmu_agen_seq against a cycle-indexed event model.
module tb_vmu_agen_seq;
  localparam int SW    = 32;
  localparam int D     = 2;
  localparam int VLMAX = 256;
  localparam int LANE  = 8;
  localparam int CW    = 5;
  localparam int VW    = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_stall = 1'b0;
  logic [CW-1:0] o_seq_vmu_cnt;
  logic [SW-1:0] o_seq_vmu_scalar;
  logic          o_addr_vld, o_addr_last, o_busy, o_done;

  int n_vec = 0;
  int n_err = 0;

  bit stall_pat[0:511];
  bit exp_vld[0:511];
  bit exp_last[0:511];
  int exp_cnt[0:511];

  vmu_agen_seq_if #(.SCALAR_WIDTH(SW), .VL_W(VW)) cmd_if ();

  vmu_agen_seq #(
    .SCALAR_WIDTH(SW), .COMMON_AGEN_DELAY(D), .SYS_VLMAX(VLMAX), .SYS_NUM_LANE(LANE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd              (cmd_if.slave),
    .i_stall          (i_stall),
    .o_seq_vmu_cnt    (o_seq_vmu_cnt),
    .o_seq_vmu_scalar (o_seq_vmu_scalar),
    .o_addr_vld       (o_addr_vld),
    .o_addr_last      (o_addr_last),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_rdy"},    32'(cmd_if.o_cmd_rdy), 32'd1);
    chk({tag, "_busy"},   32'(o_busy),           32'd0);
    chk({tag, "_done"},   32'(o_done),           32'd0);
    chk({tag, "_vld"},    32'(o_addr_vld),       32'd0);
    chk({tag, "_last"},   32'(o_addr_last),      32'd0);
    chk({tag, "_cnt"},    32'(o_seq_vmu_cnt),    32'd0);
    chk({tag, "_scalar"}, o_seq_vmu_scalar,      32'd0);
  endtask

  // mode: 0 no stall, 1 random stalls, 2 stall cycles 2..4. Entered and left at posedge+1.
  task automatic run_cmd(input int vl, input logic [31:0] scalar, input int mode, input bit hold);
    int vle, beats, issued, c_last, done_c;
    vle   = (vl > VLMAX) ? VLMAX : vl;
    beats = (vle + LANE - 1) / LANE;
    for (int c = 0; c < 512; c++) begin
      exp_vld[c] = 1'b0; exp_last[c] = 1'b0; exp_cnt[c] = 0; stall_pat[c] = 1'b0;
    end
    for (int c = 1; c < 512; c++) begin
      if (mode == 1)      stall_pat[c] = (c < 200) && ($urandom_range(0, 3) == 0);
      else if (mode == 2) stall_pat[c] = (c >= 2) && (c <= 4);
    end
    issued = 0;
    c_last = 0;
    for (int c = 1; c < 400 && issued < beats; c++) begin
      exp_cnt[c] = issued;
      if (!stall_pat[c]) begin
        exp_vld[c+D]  = 1'b1;
        exp_last[c+D] = (issued == beats - 1);
        issued++;
        c_last = c;
      end
    end
    done_c = (beats == 0) ? 1 : c_last + D + 1;

    cmd_if.i_cmd_vld    = 1'b1;
    cmd_if.i_cmd_scalar = scalar;
    cmd_if.i_cmd_vl     = VW'(vl);
    @(negedge clk);
    chk("accept_rdy",  32'(cmd_if.o_cmd_rdy), 32'd1);
    chk("accept_busy", 32'(o_busy),           32'd0);
    chk("accept_vld",  32'(o_addr_vld),       32'd0);
    @(posedge clk); #1;
    if (!hold) cmd_if.i_cmd_vld = 1'b0;

    for (int c = 1; c <= done_c; c++) begin
      i_stall = stall_pat[c];
      @(negedge clk);
      chk("rdy",  32'(cmd_if.o_cmd_rdy), 32'd0);
      chk("busy", 32'(o_busy),           32'(beats > 0));
      chk("done", 32'(o_done),           32'(c == done_c));
      chk("vld",  32'(o_addr_vld),       32'(exp_vld[c]));
      chk("last", 32'(o_addr_last),      32'(exp_last[c]));
      if (beats > 0 && c <= c_last) begin
        chk("cnt",    32'(o_seq_vmu_cnt), 32'(exp_cnt[c]));
        chk("scalar", o_seq_vmu_scalar,   scalar);
      end
      @(posedge clk); #1;
    end
    i_stall = 1'b0;
  endtask

  initial begin
    cmd_if.i_cmd_vld    = 1'b0;
    cmd_if.i_cmd_scalar = '0;
    cmd_if.i_cmd_vl     = '0;
    repeat (2) @(negedge clk);
    chk_idle_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(16,  32'h0000_0100, 0, 1'b0);
    run_cmd(13,  32'h0000_2000, 0, 1'b0);
    run_cmd(300, 32'hABCD_0000, 0, 1'b0);
    run_cmd(256, 32'h0000_0040, 0, 1'b0);
    run_cmd(0,   32'h0000_0055, 0, 1'b0);
    run_cmd(32,  32'h0000_3000, 2, 1'b0);
    run_cmd(511, 32'h0000_0007, 1, 1'b0);

    // Abort a vl=64 command mid-issue with an asynchronous reset
    cmd_if.i_cmd_vld    = 1'b1;
    cmd_if.i_cmd_scalar = 32'hDEAD_0000;
    cmd_if.i_cmd_vl     = VW'(64);
    @(posedge clk); #1;
    cmd_if.i_cmd_vld = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_idle_reset("abort");
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_done", 32'(o_done),     32'd0);
      chk("abort_hold_vld",  32'(o_addr_vld), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(8, 32'h0000_0800, 0, 1'b0);

    // Valid held high across two commands
    run_cmd(24, 32'h0000_4000, 0, 1'b1);
    run_cmd(16, 32'h0000_5000, 0, 1'b0);

    for (int k = 0; k < 14; k++)
      run_cmd(int'($urandom_range(0, 320)), $urandom, 1, ($urandom_range(0, 3) == 0));

    cmd_if.i_cmd_vld = 1'b0;
    @(negedge clk);
    chk("final_rdy",  32'(cmd_if.o_cmd_rdy), 32'd1);
    chk("final_busy", 32'(o_busy),           32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vmu_agen_seq.md
Name: vmu_agen_seq

Overview:
- Sequencer that drives the VMU scalar address generator (addr_gen) for one vector memory command at a time.
- Accepts a command (scalar operand, vector length) over a valid/ready handshake and steps the beat counter 0..beats-1 into addr_gen.
- Tracks the fixed COMMON_AGEN_DELAY latency so every o_scalar_addr leaving addr_gen is tagged with a valid and a last flag for the VMU memory request stage.
- Sits between the VMU instruction sequencer and addr_gen.

Parameters:
- SCALAR_WIDTH, 32, width of the scalar operand and of the generated address.
- COMMON_AGEN_DELAY, 2, addr_gen input-to-output latency in cycles (range 0..8).
- SYS_VLMAX, 256, maximum vector length in elements.
- SYS_NUM_LANE, 8, elements handled per beat.
- CNT_W, $clog2(SYS_VLMAX/SYS_NUM_LANE), beat counter width (5 by default).
- VL_W, $clog2(SYS_VLMAX)+1, vector length field width (9 by default).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_cmd_vld  in  1  command valid.
- o_cmd_rdy  out  1  command ready.
- i_cmd_scalar  in  SCALAR_WIDTH  scalar operand forwarded to addr_gen.
- i_cmd_vl  in  VL_W  vector length in elements.
- i_stall  in  1  freezes beat issue; in-flight beats still drain.
- o_seq_vmu_cnt  out  CNT_W  beat index to addr_gen i_seq_vmu_cnt.
- o_seq_vmu_scalar  out  SCALAR_WIDTH  operand to addr_gen i_seq_vmu_scalar.
- o_addr_vld  out  1  o_scalar_addr of addr_gen is valid this cycle.
- o_addr_last  out  1  qualifies the final beat of the command.
- o_busy  out  1  a command is active (issuing or draining).
- o_done  out  1  one-cycle pulse when the command has fully drained.

Behaviour:
Reset:
- The FSM goes to IDLE.
- All outputs are 0 except o_cmd_rdy, which is 1.
- Delay-line contents are cleared.
- An assertion mid-command aborts it immediately; no o_done is produced.

FSM states:
- IDLE:
  - o_cmd_rdy=1. A handshake (i_cmd_vld & o_cmd_rdy) latches scalar and vl.
  - vl_eff = min(i_cmd_vl, SYS_VLMAX).
  - beats = ceil(vl_eff/SYS_NUM_LANE).
  - If beats==0, o_done pulses the next cycle and the FSM stays in IDLE, with nothing issued.
  - Otherwise the FSM goes to ISSUE with cnt=0.
- ISSUE:
  - o_cmd_rdy=0, o_busy=1.
  - Each cycle with i_stall=0 issues one beat: o_seq_vmu_cnt=cnt, o_seq_vmu_scalar=latched scalar, and a {1, last} token enters the delay line.
  - last = (cnt==beats-1). After the last beat the FSM goes to DRAIN; otherwise cnt increments.
  - When i_stall=1: no token enters, cnt holds, and o_seq_vmu_cnt/o_seq_vmu_scalar hold their values.
- DRAIN:
  - o_busy=1; no issue.
  - When the delay line holds no valid token, the FSM goes to IDLE and o_done pulses for one cycle in that same transition cycle.
  - With COMMON_AGEN_DELAY=0 the DRAIN state lasts exactly one cycle.

Delay line:
- COMMON_AGEN_DELAY-stage shift register of {vld, last}, advancing every cycle regardless of i_stall.
- o_addr_vld/o_addr_last are its output, so a beat issued in cycle t appears at t+COMMON_AGEN_DELAY.
- With COMMON_AGEN_DELAY=0 it is a combinational pass-through of the issue strobe.
- o_addr_last is never 1 without o_addr_vld.

Other rules:
- o_cmd_rdy is 0 in ISSUE and DRAIN, so there is no command overlap and no back-to-back acceptance in the o_done cycle. The next command is accepted at the earliest one cycle after o_done.
- Counter arithmetic is unsigned. cnt never exceeds beats-1 and never wraps, including at vl=SYS_VLMAX (beats=32, cnt reaches 31).
- A stall asserted in the cycle the last beat would issue delays the ISSUE-to-DRAIN transition until the stall clears.

Test Plan:
- Reset, then vl=16, scalar=0x100, no stall: o_seq_vmu_cnt=0,1 on consecutive cycles; o_addr_vld high at issue+2 for 2 cycles; o_addr_last on the second beat; o_done 1 cycle after the last vld drains; o_cmd_rdy returns to 1.
- vl=13: beats=2 (rounded up). vl=300: clamped to 256, 32 beats, cnt 0..31, last at cnt=31, no wrap.
- vl=0: o_done pulses one cycle after the handshake; o_addr_vld never asserts; o_busy stays 0.
- vl=32 with i_stall=1 for 3 cycles after beat 1: cnt holds at 1 and no token is issued during the stall; 4 vld pulses total with a 3-cycle gap; the last flag appears only on beat 3.
- rst_n asserted low mid-ISSUE of a vl=64 command: outputs clear asynchronously, o_done never pulses; after release a new vl=8 command completes normally with 1 beat.
- i_cmd_vld held high across two commands: the second is accepted only after o_done of the first; the cnt sequence restarts at 0.
